// File: rtl/pc_ctrl_nwide.sv
// pc_ctrl_nwide: N-wide fetch PC controller with taken-slot masking and a circular return-address stack
module pc_ctrl_nwide #(
  parameter int XLEN = 32,
  parameter int FETCH_WIDTH = 5,
  parameter int RAS_DEPTH = 8,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        parallel_mode,
  input  logic                        fetch_ready,
  input  logic [FETCH_WIDTH-1:0]      jump_i,
  input  logic [FETCH_WIDTH-1:0]      jalr_i,
  input  logic [FETCH_WIDTH-1:0]      call_i,
  input  logic [FETCH_WIDTH-1:0]      ret_i,
  input  logic [FETCH_WIDTH*XLEN-1:0] imm_i,
  input  logic                        redirect_valid,
  input  logic [XLEN-1:0]             redirect_pc,
  output logic [FETCH_WIDTH*XLEN-1:0] inst_addr,
  output logic [FETCH_WIDTH*XLEN-1:0] current_pc,
  output logic [FETCH_WIDTH*XLEN-1:0] pc_save,
  output logic [FETCH_WIDTH-1:0]      slot_valid,
  output logic [$clog2(RAS_DEPTH):0]  ras_count,
  output logic                        ras_overflow
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = FETCH_WIDTH > 1 ? $clog2(FETCH_WIDTH) : 1;
  localparam logic [PW-1:0] P1 = 1;
  localparam logic [CW-1:0] C1 = 1;
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  logic [XLEN-1:0] pc_q, pc_d, nxt, cur_t, imm_t, tgt, top, ia0, step;
  logic [PW-1:0] ptr_q, ptr_d, wr_idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d;
  logic [FETCH_WIDTH-1:0] act, jmp, jr, tk;
  logic [TW-1:0] t;
  logic has_t, call_t, ret_t, upd, push, pop, rep, empty, full, wr_en;
  logic [XLEN-1:0] cur [FETCH_WIDTH];
  logic [XLEN-1:0] imma [FETCH_WIDTH];
  logic [XLEN-1:0] ras_q [RAS_DEPTH];

  assign jmp = jump_i & act;
  assign jr = jalr_i & act;
  assign tk = jmp | jr;
  assign has_t = |tk;

  genvar k;
  for (k = 0; k < FETCH_WIDTH; k++) begin : g_slot
    assign act[k] = parallel_mode | (k == 0);
    assign imma[k] = imm_i[k*XLEN +: XLEN] & ~XLEN'(3);
    assign cur[k] = act[k] ? pc_q + XLEN'(4*k) : pc_q;
    assign current_pc[k*XLEN +: XLEN] = cur[k];
    assign pc_save[k*XLEN +: XLEN] = tk[k] ? cur[k] + XLEN'(4) : cur[k] + imma[k];
    assign slot_valid[k] = reset & act[k] & (~has_t | (TW'(k) <= t));
    assign inst_addr[k*XLEN +: XLEN] = !reset ? RESET_PC : parallel_mode ? ia0 + XLEN'(4*k) : ia0;
  end

  // Select the lowest taken slot; scanning downward lets the lowest index win
  always_comb begin
    t = '0;
    imm_t = '0;
    call_t = 1'b0;
    ret_t = 1'b0;
    for (int i = FETCH_WIDTH - 1; i >= 0; i--)
      if (tk[i]) begin
        t = TW'(i);
        imm_t = imma[i];
        call_t = call_i[i];
        ret_t = ret_i[i] & jr[i] & ~jmp[i];
      end
  end

  assign cur_t = pc_q + XLEN'({t, 2'b00});
  assign tgt = cur_t + imm_t;
  assign top = ras_q[ptr_q - P1];
  assign empty = cnt_q == '0;
  assign full = cnt_q == FULL;
  assign step = parallel_mode ? XLEN'(4*FETCH_WIDTH) : XLEN'(4);
  assign nxt = !has_t ? pc_q + step : (ret_t & ~empty) ? top : tgt;
  assign ia0 = redirect_valid ? redirect_pc : fetch_ready ? nxt : pc_q;
  assign pc_d = ia0;

  // RAS bookkeeping: a call/ret pair rewrites the top instead of popping then pushing
  assign upd = fetch_ready & ~redirect_valid & has_t;
  assign push = upd & call_t & ~ret_t;
  assign pop = upd & ret_t & ~call_t & ~empty;
  assign rep = upd & call_t & ret_t;
  assign wr_en = reset & (push | rep);
  assign wr_idx = (rep & ~empty) ? ptr_q - P1 : ptr_q;
  assign ptr_d = redirect_valid ? '0 : (push | (rep & empty)) ? ptr_q + P1 : pop ? ptr_q - P1 : ptr_q;
  assign cnt_d = redirect_valid ? '0 : ((push & ~full) | (rep & empty)) ? cnt_q + C1 : pop ? cnt_q - C1 : cnt_q;
  assign ovf_d = ~redirect_valid & (ovf_q | (push & full));

  // Control state: held on stall, flushed by reset
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc_q <= RESET_PC;
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end

  // Stack storage needs no reset; validity is tracked by the count
  always_ff @(posedge clk)
    if (wr_en) ras_q[wr_idx] <= cur_t + XLEN'(4);

  assign ras_count = cnt_q;
  assign ras_overflow = ovf_q;
endmodule

// File: tb/tb_pc_ctrl_nwide.sv
// tb_pc_ctrl_nwide: vector table, corner sequences and random run against a queue-based reference model
module tb_pc_ctrl_nwide;
  localparam int XL = 32;
  localparam int FW = 5;
  localparam int RD = 8;
  localparam int CW = 4;
  localparam logic [XL-1:0] RPC = 32'h0;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic parallel_mode, fetch_ready, redirect_valid, ras_overflow;
  logic [FW-1:0] jump_i, jalr_i, call_i, ret_i, slot_valid;
  logic [FW*XL-1:0] imm_i, inst_addr, current_pc, pc_save;
  logic [XL-1:0] redirect_pc;
  logic [CW-1:0] ras_count;

  pc_ctrl_nwide #(.XLEN(XL), .FETCH_WIDTH(FW), .RAS_DEPTH(RD), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .parallel_mode(parallel_mode), .fetch_ready(fetch_ready),
    .jump_i(jump_i), .jalr_i(jalr_i), .call_i(call_i), .ret_i(ret_i), .imm_i(imm_i),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .inst_addr(inst_addr),
    .current_pc(current_pc), .pc_save(pc_save), .slot_valid(slot_valid),
    .ras_count(ras_count), .ras_overflow(ras_overflow));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  logic [XL-1:0] m_pc = RPC;
  logic [XL-1:0] m_ras[$];
  logic m_ovf = 1'b0;

  typedef struct {
    logic pm, fr, rv;
    logic [FW-1:0] jmp, jr, cl, rt;
    logic [FW*XL-1:0] imm;
    logic [XL-1:0] rpc, e_cur0, e_ia0;
    logic [FW-1:0] e_sv;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t tbl[14];

  task automatic cmp(input string nm, input logic [FW*XL-1:0] act, input logic [FW*XL-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [XL-1:0] al(input int k);
    return {imm_i[k*XL+2 +: XL-2], 2'b00};
  endfunction

  function automatic vec_t mk(input logic pm, fr, rv, input logic [FW-1:0] jmp, jr, cl, rt,
                              input int isl, input logic [XL-1:0] iv, rpc, cur0, ia0,
                              input logic [FW-1:0] sv, input logic [CW-1:0] cnt);
    vec_t v;
    v.pm = pm; v.fr = fr; v.rv = rv; v.jmp = jmp; v.jr = jr; v.cl = cl; v.rt = rt;
    v.imm = '0;
    v.imm[isl*XL +: XL] = iv;
    v.rpc = rpc; v.e_cur0 = cur0; v.e_ia0 = ia0; v.e_sv = sv; v.e_cnt = cnt;
    return v;
  endfunction

  task automatic idle();
    parallel_mode = 1'b1; fetch_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    jump_i = '0; jalr_i = '0; call_i = '0; ret_i = '0; imm_i = '0;
  endtask

  // Reference model: compares every output, then advances the architectural state
  task automatic settle();
    int a, t;
    logic [XL-1:0] cur[FW];
    logic [XL-1:0] nxt, ia0;
    logic [FW*XL-1:0] e_ia, e_cur, e_save;
    logic [FW-1:0] e_sv;
    logic cl, rt;
    #1;
    if (!reset) begin m_pc = RPC; m_ras.delete(); m_ovf = 1'b0; end
    a = parallel_mode ? FW : 1;
    t = -1;
    cl = 1'b0; rt = 1'b0;
    for (int k = 0; k < FW; k++) begin
      cur[k] = k < a ? m_pc + 32'(4*k) : m_pc;
      if (t < 0 && k < a && (jump_i[k] | jalr_i[k])) t = k;
    end
    if (t < 0) nxt = m_pc + 32'(4*a);
    else begin
      rt = jalr_i[t] && !jump_i[t] && ret_i[t];
      cl = call_i[t];
      nxt = (rt && m_ras.size() > 0) ? m_ras[m_ras.size()-1] : cur[t] + al(t);
    end
    ia0 = redirect_valid ? redirect_pc : fetch_ready ? nxt : m_pc;
    for (int k = 0; k < FW; k++) begin
      e_ia[k*XL +: XL] = !reset ? RPC : parallel_mode ? ia0 + 32'(4*k) : ia0;
      e_cur[k*XL +: XL] = cur[k];
      e_save[k*XL +: XL] = (k < a && (jump_i[k] | jalr_i[k])) ? cur[k] + 32'd4 : cur[k] + al(k);
      e_sv[k] = reset && k < a && (t < 0 || k <= t);
    end
    cmp("inst_addr", inst_addr, e_ia);
    cmp("current_pc", current_pc, e_cur);
    cmp("pc_save", pc_save, e_save);
    cmp("slot_valid", {155'b0, slot_valid}, {155'b0, e_sv});
    cmp("ras_count", {156'b0, ras_count}, (FW*XL)'(m_ras.size()));
    cmp("ras_overflow", {159'b0, ras_overflow}, {159'b0, m_ovf});
    if (reset && redirect_valid) begin
      m_pc = redirect_pc; m_ras.delete(); m_ovf = 1'b0;
    end else if (reset && fetch_ready) begin
      if (t >= 0) begin
        if (cl && rt) begin
          if (m_ras.size() > 0) m_ras[m_ras.size()-1] = cur[t] + 32'd4;
          else m_ras.push_back(cur[t] + 32'd4);
        end else if (cl) begin
          if (m_ras.size() == RD) begin void'(m_ras.pop_front()); m_ovf = 1'b1; end
          m_ras.push_back(cur[t] + 32'd4);
        end else if (rt && m_ras.size() > 0) void'(m_ras.pop_back());
      end
      m_pc = nxt;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    tbl[0]  = mk(1,1,0, 0,0,0,0, 0,0, 0, 32'h0,   32'h14,  5'h1F, 0);
    tbl[1]  = mk(1,1,0, 0,0,0,0, 0,0, 0, 32'h14,  32'h28,  5'h1F, 0);
    tbl[2]  = mk(1,1,0, 0,0,0,0, 0,0, 0, 32'h28,  32'h3C,  5'h1F, 0);
    tbl[3]  = mk(1,1,1, 0,0,0,0, 0,0, 32'h100, 32'h3C, 32'h100, 5'h1F, 0);
    tbl[4]  = mk(1,1,0, 5'b00100,0,0,0, 2,32'h43, 0, 32'h100, 32'h148, 5'b00111, 0);
    tbl[5]  = mk(1,1,1, 0,0,0,0, 0,0, 32'h200, 32'h148, 32'h200, 5'h1F, 0);
    tbl[6]  = mk(1,1,0, 5'b00010,0,5'b00010,0, 1,32'h1000, 0, 32'h200, 32'h1204, 5'b00011, 0);
    tbl[7]  = mk(1,1,0, 0,5'b00001,0,5'b00001, 0,0, 0, 32'h1204, 32'h208, 5'b00001, 1);
    tbl[8]  = mk(1,1,1, 0,0,0,0, 0,0, 32'h300, 32'h208, 32'h300, 5'h1F, 0);
    tbl[9]  = mk(1,1,0, 0,5'b00001,0,5'b00001, 0,32'h10, 0, 32'h300, 32'h310, 5'b00001, 0);
    tbl[10] = mk(0,1,0, 0,0,0,0, 0,0, 0, 32'h310, 32'h314, 5'b00001, 0);
    tbl[11] = mk(0,0,0, 0,0,0,0, 0,0, 0, 32'h314, 32'h314, 5'b00001, 0);
    tbl[12] = mk(0,0,1, 0,0,0,0, 0,0, 32'h400, 32'h314, 32'h400, 5'b00001, 0);
    tbl[13] = mk(1,1,0, 0,0,0,0, 0,0, 0, 32'h400, 32'h414, 5'h1F, 0);

    idle();
    @(negedge clk);
    settle();
    cmp("rst_slot_valid", {155'b0, slot_valid}, '0);
    tick();
    reset = 1'b1;

    foreach (tbl[i]) begin
      parallel_mode = tbl[i].pm; fetch_ready = tbl[i].fr; redirect_valid = tbl[i].rv;
      redirect_pc = tbl[i].rpc; jump_i = tbl[i].jmp; jalr_i = tbl[i].jr;
      call_i = tbl[i].cl; ret_i = tbl[i].rt; imm_i = tbl[i].imm;
      settle();
      cmp($sformatf("v%0d_cur0", i), current_pc[XL-1:0], tbl[i].e_cur0);
      cmp($sformatf("v%0d_ia0", i), inst_addr[XL-1:0], tbl[i].e_ia0);
      cmp($sformatf("v%0d_valid", i), {155'b0, slot_valid}, {155'b0, tbl[i].e_sv});
      cmp($sformatf("v%0d_cnt", i), {156'b0, ras_count}, {156'b0, tbl[i].e_cnt});
      if (i == 0) cmp("first_ia4", inst_addr[4*XL +: XL], 32'h24);
      if (i == 4) cmp("save2", pc_save[2*XL +: XL], 32'h10C);
      tick();
    end

    // Nine calls overflow the stack; eight rets unwind the newest entries, the ninth falls back
    idle(); redirect_valid = 1'b1; redirect_pc = 32'h1000; settle(); tick();
    idle(); jump_i = 5'b00001; call_i = 5'b00001; imm_i[XL-1:0] = 32'h100;
    for (int i = 0; i < RD + 1; i++) begin settle(); tick(); end
    idle(); jalr_i = 5'b00001; ret_i = 5'b00001; imm_i[XL-1:0] = 32'h40;
    settle();
    cmp("ovf_cnt", {156'b0, ras_count}, 160'd8);
    cmp("ovf_flag", {159'b0, ras_overflow}, 160'd1);
    tick();
    for (int j = 1; j < RD; j++) begin
      settle();
      cmp($sformatf("ret%0d", j), inst_addr[XL-1:0], 32'h1004 + 32'h100 * 32'(RD - j));
      tick();
    end
    settle();
    cmp("ret_fallback", inst_addr[XL-1:0], 32'h1144);
    cmp("ret_empty", {156'b0, ras_count}, '0);
    tick();

    // Stall, redirect during stall, stall again
    idle(); redirect_valid = 1'b1; redirect_pc = 32'h500; settle(); tick();
    idle(); jump_i = 5'b00001; call_i = 5'b00001; imm_i[XL-1:0] = 32'h100; settle(); tick();
    idle(); fetch_ready = 1'b0; settle();
    cmp("stall_cur0", current_pc[XL-1:0], 32'h600);
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h400; settle();
    cmp("stall_redir_ia0", inst_addr[XL-1:0], 32'h400);
    tick();
    redirect_valid = 1'b0; settle();
    cmp("after_redir_cur0", current_pc[XL-1:0], 32'h400);
    cmp("after_redir_cnt", {156'b0, ras_count}, '0);
    tick();

    for (int n = 0; n < 400; n++) begin
      parallel_mode = $urandom_range(0, 3) != 0;
      fetch_ready = $urandom_range(0, 3) != 0;
      redirect_valid = $urandom_range(0, 15) == 0;
      redirect_pc = $urandom;
      for (int k = 0; k < FW; k++) begin
        jump_i[k] = $urandom_range(0, 5) == 0;
        jalr_i[k] = $urandom_range(0, 5) == 0;
        call_i[k] = $urandom_range(0, 2) == 0;
        ret_i[k] = $urandom_range(0, 2) == 0;
        imm_i[k*XL +: XL] = $urandom_range(0, 255) << 2 | 32'($urandom_range(0, 3));
      end
      settle();
      tick();
    end

    // Asynchronous reset with a call pending
    idle(); jump_i = 5'b00001; call_i = 5'b00001; imm_i[XL-1:0] = 32'h80;
    settle(); tick();
    settle();
    reset = 1'b0;
    settle();
    cmp("rst_ia", inst_addr, '0);
    cmp("rst_valid", {155'b0, slot_valid}, '0);
    cmp("rst_cnt", {156'b0, ras_count}, '0);
    cmp("rst_ovf", {159'b0, ras_overflow}, '0);
    tick();
    reset = 1'b1; idle();
    settle();
    cmp("post_rst_cnt", {156'b0, ras_count}, '0);
    cmp("post_rst_cur0", current_pc[XL-1:0], RPC);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
